mac_seq_ctrl: RTL and testbench
===============================

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, operand width of act/w.
REQ-002 The block SHALL have parameter ACC_WIDTH, default DATA_WIDTH+16, accumulator width.
REQ-003 The block SHALL have parameter RESULT_WIDTH, default 2*DATA_WIDTH, result width.
REQ-004 The block SHALL have parameter LEN_WIDTH, default 8, width of the vector-length field.
REQ-005 The block SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, reset: synchronous, active-high.
REQ-007 The block SHALL have port start, input, 1, request to begin one dot product.
REQ-008 The block SHALL have port vec_len, input, LEN_WIDTH, number of act/w pairs; sampled on an accepted start.
REQ-009 The block SHALL have port bias, input signed ACC_WIDTH, initial accumulator value; sampled on an accepted start.
REQ-010 The block SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-011 The block SHALL have ports in_valid (input, 1), in_ready (output, 1), act (input signed DATA_WIDTH) and w (input signed DATA_WIDTH), the operand stream.
REQ-012 The block SHALL have ports mac_en (output, 1), mac_load_accum (output, 1), mac_act (output signed DATA_WIDTH), mac_w (output signed DATA_WIDTH) and mac_accum_prev (output signed ACC_WIDTH), which drive the MAC.
REQ-013 The block SHALL have port mac_result, input signed RESULT_WIDTH, the MAC's registered result.
REQ-014 The block SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output signed RESULT_WIDTH), the result stream.

Function
REQ-015 The block SHALL implement the states IDLE, RUN, WAIT and OUT.
REQ-016 IDLE SHALL hold start_ok = 1; when start=1 it SHALL latch vec_len into a down-counter and bias into a register.
REQ-017 On an accepted start, the block SHALL go to RUN when vec_len>0, and to OUT with out_data=0 when vec_len=0.
REQ-018 The block SHALL ignore start in any state other than IDLE.
REQ-019 in_ready SHALL be 1 only in RUN; a beat SHALL transfer when in_valid=1 and in_ready=1.
REQ-020 On each transferred beat, mac_en SHALL be 1 in that same cycle, with mac_act=act and mac_w=w passed combinationally.
REQ-021 mac_load_accum SHALL be 1 only on the first beat of a vector; mac_accum_prev SHALL always equal the latched bias.
REQ-022 In cycles with no transfer, mac_en SHALL be 0 and mac_act/mac_w SHALL be 0; in_valid=0 gaps SHALL stall without corrupting the count.
REQ-023 The counter SHALL decrement per beat; on the beat at count=1 the block SHALL go to WAIT.
REQ-024 WAIT SHALL last exactly one cycle, SHALL capture mac_result into out_data, and SHALL go to OUT.
REQ-025 OUT SHALL drive out_valid=1 with out_data held stable until out_ready=1, then go to IDLE; with out_ready held at 1, out_valid SHALL last one cycle.
REQ-026 Latency SHALL be: last beat in cycle T -> out_valid=1 in cycle T+2.
REQ-027 The block SHALL count vec_len as unsigned; max vector = 2^LEN_WIDTH-1, with no wrap past 0.
REQ-028 A start in the same cycle that OUT completes SHALL be ignored; start is honoured from IDLE only.

Reset
REQ-029 While reset=1 at a clock edge, the state SHALL become IDLE and counter, bias register and out_data SHALL become 0.
REQ-030 During reset, busy, in_ready, out_valid, mac_en and mac_load_accum SHALL be 0.
REQ-031 Reset in any state, including mid-vector, SHALL abort the operation and produce no out_valid.

Verification
REQ-032 The bench SHALL run vec_len=3, bias=0, act=w=64 for 3 back-to-back beats -> out_valid 2 cycles after the last beat, out_data=0x0030.
REQ-033 The bench SHALL run vec_len=4, bias=0, act=-128, w=127 -> out_data=0xFF02; mac_load_accum=1 on beat 1 only.
REQ-034 The bench SHALL run vec_len=2 with in_valid gaps of 3 cycles between beats -> exactly 2 mac_en pulses, correct result.
REQ-035 The bench SHALL run vec_len=0 -> out_valid the cycle after start, out_data=0, no mac_en.
REQ-036 The bench SHALL hold out_ready=0 for 5 cycles in OUT -> out_valid and out_data stable, and start ignored.
REQ-037 The bench SHALL assert reset after beat 2 of a vec_len=5 vector -> IDLE, no out_valid; a following vec_len=1 run SHALL produce the correct result.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mac_seq_ctrl
//   Sequences one dot product through an external registered MAC. A start in
//   IDLE latches the vector length and the bias, operand beats are streamed to
//   the MAC as they arrive, and the MAC's result is captured one cycle after
//   the last beat and offered on a valid/ready result port.
//
// Ports
//   clk, reset       : clock (rising edge) and synchronous active-high reset
//   start            : request a dot product (honoured only in IDLE)
//   vec_len          : number of act/w pairs, unsigned, sampled on start
//   bias             : initial accumulator value, sampled on start
//   busy             : high whenever not IDLE
//   in_valid/in_ready: operand stream handshake; act, w are the operands
//   mac_en           : a beat is transferred this cycle
//   mac_load_accum   : first beat of the vector, MAC loads mac_accum_prev
//   mac_act/mac_w    : operands to the MAC (zero when no transfer)
//   mac_accum_prev   : latched bias
//   mac_result       : registered MAC result
//   out_valid/out_ready/out_data : result stream
// -----------------------------------------------------------------------------
module mac_seq_ctrl #(
   parameter int DATA_WIDTH   = 8,
   parameter int ACC_WIDTH    = DATA_WIDTH + 16,
   parameter int RESULT_WIDTH = 2 * DATA_WIDTH,
   parameter int LEN_WIDTH    = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic        [LEN_WIDTH-1:0]    vec_len,
   input  logic signed [ACC_WIDTH-1:0]    bias,
   output logic                           busy,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic signed [DATA_WIDTH-1:0]   act,
   input  logic signed [DATA_WIDTH-1:0]   w,
   output logic                           mac_en,
   output logic                           mac_load_accum,
   output logic signed [DATA_WIDTH-1:0]   mac_act,
   output logic signed [DATA_WIDTH-1:0]   mac_w,
   output logic signed [ACC_WIDTH-1:0]    mac_accum_prev,
   input  logic signed [RESULT_WIDTH-1:0] mac_result,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic signed [RESULT_WIDTH-1:0] out_data
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_WAIT = 2'd2,
      S_OUT  = 2'd3
   } state_t;

   state_t                         state_q, state_d;
   logic        [LEN_WIDTH-1:0]    cnt_q, cnt_d;
   logic signed [ACC_WIDTH-1:0]    bias_q, bias_d;
   logic signed [RESULT_WIDTH-1:0] out_data_q, out_data_d;
   logic                           first_q, first_d;

   logic start_ok;
   logic beat;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bias_q     <= '0;
         out_data_q <= '0;
         first_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bias_q     <= bias_d;
         out_data_q <= out_data_d;
         first_q    <= first_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bias_d     = bias_q;
      out_data_d = out_data_q;
      first_d    = first_q;

      start_ok = (state_q == S_IDLE);
      // Outputs are forced quiet while reset is asserted, before the flops clear.
      beat     = (state_q == S_RUN) && in_valid && !reset;

      case (state_q)
         S_IDLE: begin
            if (start_ok && start) begin
               cnt_d   = vec_len;
               bias_d  = bias;
               first_d = 1'b1;
               if (vec_len != '0) begin
                  state_d = S_RUN;
               end else begin
                  // Empty vector: nothing reaches the MAC, result is zero.
                  out_data_d = '0;
                  state_d    = S_OUT;
               end
            end
         end
         S_RUN: begin
            if (beat) begin
               cnt_d   = cnt_q - LEN_WIDTH'(1);
               first_d = 1'b0;
               if (cnt_q == LEN_WIDTH'(1)) begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            // The MAC registered the last beat on the previous edge.
            out_data_d = mac_result;
            state_d    = S_OUT;
         end
         S_OUT: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy           = (state_q != S_IDLE) && !reset;
      in_ready       = (state_q == S_RUN) && !reset;
      mac_en         = beat;
      mac_load_accum = beat && first_q;
      mac_act        = beat ? act : '0;
      mac_w          = beat ? w : '0;
      mac_accum_prev = bias_q;
      out_valid      = (state_q == S_OUT) && !reset;
      out_data       = out_data_q;
   end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
module tb_mac_seq_ctrl;

   localparam int DW = 8;
   localparam int AW = DW + 16;
   localparam int RW = 2 * DW;
   localparam int LW = 8;

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic                  start = 1'b0;
   logic        [LW-1:0]  vec_len = '0;
   logic signed [AW-1:0]  bias = '0;
   logic                  busy;
   logic                  in_valid = 1'b0;
   logic                  in_ready;
   logic signed [DW-1:0]  act = '0;
   logic signed [DW-1:0]  w = '0;
   logic                  mac_en;
   logic                  mac_load_accum;
   logic signed [DW-1:0]  mac_act;
   logic signed [DW-1:0]  mac_w;
   logic signed [AW-1:0]  mac_accum_prev;
   logic signed [RW-1:0]  mac_result;
   logic                  out_valid;
   logic                  out_ready = 1'b0;
   logic signed [RW-1:0]  out_data;

   always #5 clk = ~clk;

   mac_seq_ctrl #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .RESULT_WIDTH(RW), .LEN_WIDTH(LW)) dut (
      .clk(clk), .reset(reset), .start(start), .vec_len(vec_len), .bias(bias),
      .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .act(act), .w(w),
      .mac_en(mac_en), .mac_load_accum(mac_load_accum), .mac_act(mac_act), .mac_w(mac_w),
      .mac_accum_prev(mac_accum_prev), .mac_result(mac_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   // External MAC: registered accumulator, result is the accumulator scaled
   // down by DW fraction bits.
   logic signed [AW-1:0]   mac_acc = '0;
   logic signed [2*DW-1:0] prod;
   assign prod = mac_act * mac_w;
   always @(posedge clk) begin
      if (mac_en) mac_acc <= (mac_load_accum ? mac_accum_prev : mac_acc) + AW'(prod);
   end
   assign mac_result = RW'(mac_acc >>> DW);

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int en_cnt = 0, ld_cnt = 0, ov_cnt = 0;

   task automatic chk(input string nm, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h expected=%0h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   // Behavioural reference: tracks beats still owed, a one-cycle pending
   // result, and whether a result is on offer; the result itself is the plain
   // integer dot product plus bias, scaled by 2^-DW and truncated to RW bits.
   bit            armed  = 1'b0;
   bit            m_idle = 1'b1;
   int            m_left = 0;
   bit            m_pend = 1'b0;
   bit            m_show = 1'b0;
   bit            m_first = 1'b0;
   longint        m_acc  = 0;
   longint        m_bias = 0;
   logic [RW-1:0] m_result = '0;

   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         armed = 1'b1;
         m_idle = 1'b1; m_left = 0; m_pend = 1'b0; m_show = 1'b0; m_first = 1'b0;
         m_acc = 0; m_bias = 0; m_result = '0;
      end else if (m_idle) begin
         if (start) begin
            m_bias = bias; m_acc = bias; m_first = 1'b1; m_idle = 1'b0;
            if (vec_len == 0) begin
               m_result = '0; m_show = 1'b1;
            end else begin
               m_left = int'(vec_len);
            end
         end
      end else if (m_left > 0) begin
         if (in_valid) begin
            m_acc += longint'(act) * longint'(w);
            m_first = 1'b0;
            m_left--;
            if (m_left == 0) m_pend = 1'b1;
         end
      end else if (m_pend) begin
         m_pend = 1'b0; m_show = 1'b1;
         m_result = RW'(m_acc >>> DW);
      end else if (m_show && out_ready) begin
         m_show = 1'b0; m_idle = 1'b1;
      end
   end

   // Cycle-by-cycle comparison against the reference, away from the active edge.
   always @(negedge clk) begin
      if (armed) begin : cmp
         bit e_rdy, e_en;
         e_rdy = !reset && (m_left > 0);
         e_en  = e_rdy && in_valid;
         chk("busy", busy, !reset && !m_idle);
         chk("in_ready", in_ready, e_rdy);
         chk("mac_en", mac_en, e_en);
         chk("mac_load_accum", mac_load_accum, e_en && m_first);
         chk("mac_act", longint'(mac_act), e_en ? longint'(act) : 0);
         chk("mac_w", longint'(mac_w), e_en ? longint'(w) : 0);
         chk("mac_accum_prev", longint'(mac_accum_prev), m_bias);
         chk("out_valid", out_valid, !reset && m_show);
         chk("out_data", longint'($unsigned(out_data)), longint'(m_result));
         if (mac_en) en_cnt++;
         if (mac_load_accum) ld_cnt++;
         if (out_valid) ov_cnt++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full dot product; reports captured result, latency (from last beat,
   // or from start for an empty vector), and mac_en / mac_load_accum pulses.
   task automatic run_vec(input int len, input longint b, input int gmax, input bit rnd,
                          input int fa, input int fw, input int hold,
                          output logic [RW-1:0] got, output int lat,
                          output int ens, output int lds);
      int  s_cyc, last_cyc, e0, l0;
      bit  seen;
      e0 = en_cnt; l0 = ld_cnt; got = '0; lat = -1; ens = 0; lds = 0;
      start = 1'b1; vec_len = LW'(len); bias = AW'(b);
      s_cyc = cyc; last_cyc = cyc;
      step();
      start = 1'b0; vec_len = LW'($urandom);
      for (int i = 0; i < len; i++) begin
         int g;
         g = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
         repeat (g) begin
            in_valid = 1'b0; act = DW'($urandom); w = DW'($urandom);
            step();
         end
         in_valid = 1'b1;
         act = rnd ? DW'($urandom) : DW'(fa);
         w   = rnd ? DW'($urandom) : DW'(fw);
         last_cyc = cyc;
         step();
      end
      in_valid = 1'b0; act = '0; w = '0;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         if (out_valid) seen = 1'b1;
         else step();
      end
      if (!seen) begin
         chk("out_valid_timeout", 0, 1);
         return;
      end
      got = $unsigned(out_data);
      lat = cyc - ((len > 0) ? last_cyc : s_cyc);
      repeat (hold) begin
         out_ready = 1'b0; start = 1'b1; vec_len = LW'($urandom);
         step();
         chk("hold_valid", out_valid, 1);
         chk("hold_data", longint'($unsigned(out_data)), longint'(got));
      end
      // A start coinciding with the completing handshake must be ignored.
      out_ready = 1'b1; start = 1'b1; vec_len = 8'd3;
      step();
      out_ready = 1'b0; start = 1'b0;
      chk("back_to_idle", busy, 0);
      ens = en_cnt - e0;
      lds = ld_cnt - l0;
   endtask

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [RW-1:0] got;
      int lat, ens, lds, ov0;
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", longint'($unsigned(out_data)), 0);
      chk("rst_in_ready", in_ready, 0);
      step();

      // 3 x (64*64) = 12288, scaled by 2^-8 -> 0x0030
      run_vec(3, 0, 0, 1'b0, 64, 64, 0, got, lat, ens, lds);
      chk("s1_data", got, 16'h0030);
      chk("s1_latency", lat, 2);
      chk("s1_mac_en", ens, 3);

      // 4 x (-128*127) = -65024 -> -254 -> 0xFF02
      run_vec(4, 0, 0, 1'b0, -128, 127, 0, got, lat, ens, lds);
      chk("s2_data", got, 16'hFF02);
      chk("s2_load_pulses", lds, 1);
      chk("s2_mac_en", ens, 4);

      // gaps of 3 idle cycles: 2 x (100*-50) = -10000 -> -40 -> 0xFFD8
      begin
         int s_e0;
         s_e0 = en_cnt;
         start = 1'b1; vec_len = 8'd2; bias = '0;
         step();
         start = 1'b0;
         for (int i = 0; i < 2; i++) begin
            repeat (3) begin in_valid = 1'b0; act = DW'($urandom); w = DW'($urandom); step(); end
            in_valid = 1'b1; act = 8'sd100; w = -8'sd50;
            step();
         end
         in_valid = 1'b0; act = '0; w = '0;
         step(); step();
         chk("s3_out_valid", out_valid, 1);
         chk("s3_data", longint'($unsigned(out_data)), 16'hFFD8);
         chk("s3_mac_en", en_cnt - s_e0, 2);
         out_ready = 1'b1; step(); out_ready = 1'b0;
      end

      // empty vector
      run_vec(0, 12345, 0, 1'b1, 0, 0, 0, got, lat, ens, lds);
      chk("s4_data", got, 16'h0000);
      chk("s4_latency", lat, 1);
      chk("s4_mac_en", ens, 0);

      // held result with start pressure: (256 + 12288) >> 8 = 49
      run_vec(3, 256, 0, 1'b0, 64, 64, 5, got, lat, ens, lds);
      chk("s5_data", got, 16'h0031);

      // reset mid-vector
      ov0 = ov_cnt;
      start = 1'b1; vec_len = 8'd5; bias = AW'(777);
      step();
      start = 1'b0;
      repeat (2) begin in_valid = 1'b1; act = DW'($urandom); w = DW'($urandom); step(); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      repeat (8) step();
      in_valid = 1'b0;
      chk("s6_no_out_valid", ov_cnt - ov0, 0);
      chk("s6_idle", busy, 0);
      // (1024 + 16*32) >> 8 = 6
      run_vec(1, 1024, 0, 1'b0, 16, 32, 0, got, lat, ens, lds);
      chk("s6_after_data", got, 16'h0006);

      // randomized runs
      for (int r = 0; r < 25; r++) begin
         longint b;
         b = longint'($urandom_range(200000, 0)) - 100000;
         run_vec(int'($urandom_range(12, 1)), b, 2, 1'b1, 0, 0,
                 int'($urandom_range(3, 0)), got, lat, ens, lds);
      end
      // longest vector
      run_vec(255, 0, 0, 1'b1, 0, 0, 0, got, lat, ens, lds);
      chk("max_len_mac_en", ens, 255);

      repeat (3) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
